// File: rtl/aria_pkg.sv
// Shared ARIA definitions: key-length codes, round counts, sequencer states.
package aria_pkg;

   localparam logic [1:0] KLEN_128  = 2'd0;
   localparam logic [1:0] KLEN_192  = 2'd1;
   localparam logic [1:0] KLEN_256  = 2'd2;
   localparam logic [1:0] KLEN_RSVD = 2'd3;

   localparam int NR_128 = 12;
   localparam int NR_192 = 14;
   localparam int NR_256 = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Number of rounds for a key-length code; the reserved code maps to the
   // 128-bit count but is rejected before it is ever used.
   function automatic logic [4:0] nr_of_klen(input logic [1:0] klen);
      logic [4:0] nr;
      case (klen)
         KLEN_128: nr = 5'(NR_128);
         KLEN_192: nr = 5'(NR_192);
         KLEN_256: nr = 5'(NR_256);
         default:  nr = 5'(NR_128);
      endcase
      return nr;
   endfunction

endpackage

// File: rtl/aria_rkey_sched_if.sv
// Key-load / round-key bundle between key expansion, round engine and the
// round-key sequencer.
interface aria_rkey_sched_if #(
   parameter int KW = 128
);
   logic [1:0]    klen;
   logic          wr_en;
   logic [4:0]    wr_idx;
   logic [KW-1:0] wr_key;
   logic          start;
   logic          dec;
   logic          adv;
   logic [KW-1:0] rkey;
   logic [KW-1:0] rkey_final;
   logic          rkey_valid;
   logic [3:0]    round_count;
   logic          round_last;
   logic          done;
   logic          err;

   // Controller side: loads keys, starts sequences, advances rounds.
   modport master (
      output klen, wr_en, wr_idx, wr_key, start, dec, adv,
      input  rkey, rkey_final, rkey_valid, round_count, round_last, done, err
   );

   // Sequencer side.
   modport slave (
      input  klen, wr_en, wr_idx, wr_key, start, dec, adv,
      output rkey, rkey_final, rkey_valid, round_count, round_last, done, err
   );
endinterface

// File: rtl/aria_diffusion.sv
// ARIA diffusion layer A: involutive 128->128 byte-wise XOR network.
// Byte 0 is bits [127:120]; each output byte is the XOR of 7 input bytes.
module aria_diffusion (
   input  logic [127:0] x,
   output logic [127:0] y
);

   // Row j has bit i set when input byte i feeds output byte j.
   localparam logic [15:0] ROW_MASK [16] = '{
      16'h6358, 16'h93A4, 16'h9C52, 16'h6CA1,
      16'hC925, 16'hC61A, 16'h3685, 16'h394A,
      16'hA493, 16'h5863, 16'hA16C, 16'h529C,
      16'h1AC6, 16'h25C9, 16'h4A39, 16'h8536
   };

   function automatic logic [7:0] row_xor(input logic [15:0] mask, input logic [127:0] v);
      logic [7:0] acc;
      acc = 8'h00;
      for (int j = 0; j < 16; j++) begin
         if (mask[j]) acc = acc ^ v[127-8*j -: 8];
      end
      return acc;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_byte
         assign y[127-8*gi -: 8] = row_xor(ROW_MASK[gi], x);
      end
   endgenerate

endmodule

// File: rtl/aria_rkey_sched.sv
// ARIA round-key sequencer: stores ek[0..NR] from the key expansion and
// serves one round key per round in encryption or decryption order.
module aria_rkey_sched
   import aria_pkg::*;
#(
   parameter int MAX_KEYS = 17,
   parameter int KW       = 128
) (
   input logic              clk,
   input logic              rst_n,
   aria_rkey_sched_if.slave bus
);

   localparam logic [5:0] MAX_KEYS_W = 6'(MAX_KEYS);

   logic [KW-1:0] ek_reg [MAX_KEYS];

   state_t        state_reg, state_next;
   logic          dec_reg, dec_next;
   logic [4:0]    nr_reg, nr_next;
   logic [3:0]    rc_reg, rc_next;
   logic [KW-1:0] rkey_reg, rkey_next;
   logic [KW-1:0] final_reg, final_next;
   logic          valid_reg, valid_next;
   logic          err_reg, err_next;

   logic          idx_ok;
   logic          wr_ok;
   logic [3:0]    rc_inc;
   logic [4:0]    nr_start;
   logic [4:0]    rd_idx;
   logic [4:0]    fin_idx;
   logic          use_a;
   logic [KW-1:0] rd_raw;
   logic [KW-1:0] fin_raw;
   logic [KW-1:0] a_out;
   logic [KW-1:0] key_sel;
   logic          round_last;

   assign idx_ok     = {1'b0, bus.wr_idx} < MAX_KEYS_W;
   assign wr_ok      = (state_reg == ST_IDLE) && bus.wr_en && idx_ok;
   assign rc_inc     = rc_reg + 4'd1;
   assign nr_start   = nr_of_klen(bus.klen);
   assign round_last = ({1'b0, rc_reg} == (nr_reg - 5'd1));

   // Key storage: cleared on reset, written only while idle with a legal index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_KEYS; i++) ek_reg[i] <= '0;
      end else if (wr_ok) begin
         ek_reg[bus.wr_idx] <= bus.wr_key;
      end
   end

   // Read addresses: first-round and final keys at start, next round while running.
   always_comb begin
      rd_idx  = 5'd0;
      fin_idx = 5'd0;
      use_a   = 1'b0;
      if (state_reg == ST_IDLE) begin
         rd_idx  = bus.dec ? nr_start : 5'd0;
         fin_idx = bus.dec ? 5'd0 : nr_start;
      end else begin
         rd_idx = dec_reg ? (nr_reg - {1'b0, rc_inc}) : {1'b0, rc_inc};
         use_a  = dec_reg;
      end
   end

   // Round-key read with bypass so a start sees a key written in the same cycle.
   always_comb begin
      rd_raw = ek_reg[rd_idx];
      if (wr_ok && (bus.wr_idx == rd_idx)) rd_raw = bus.wr_key;
   end

   // Final-key read with the same same-cycle bypass.
   always_comb begin
      fin_raw = ek_reg[fin_idx];
      if (wr_ok && (bus.wr_idx == fin_idx)) fin_raw = bus.wr_key;
   end

   aria_diffusion u_diff (
      .x (rd_raw),
      .y (a_out)
   );

   assign key_sel = use_a ? a_out : rd_raw;

   // Sequencer next-state and register updates.
   always_comb begin
      state_next = state_reg;
      dec_next   = dec_reg;
      nr_next    = nr_reg;
      rc_next    = rc_reg;
      rkey_next  = rkey_reg;
      final_next = final_reg;
      valid_next = valid_reg;
      err_next   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.wr_en && !idx_ok) err_next = 1'b1;
            if (bus.start) begin
               if (bus.klen == KLEN_RSVD) begin
                  err_next = 1'b1;
               end else begin
                  dec_next   = bus.dec;
                  nr_next    = nr_start;
                  rc_next    = 4'd0;
                  rkey_next  = key_sel;
                  final_next = fin_raw;
                  valid_next = 1'b1;
                  state_next = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (bus.wr_en || bus.start) err_next = 1'b1;
            if (bus.adv && valid_reg) begin
               if (round_last) begin
                  valid_next = 1'b0;
                  state_next = ST_DONE;
               end else begin
                  rc_next   = rc_inc;
                  rkey_next = key_sel;
               end
            end
         end
         ST_DONE: begin
            if (bus.wr_en || bus.start) err_next = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         dec_reg   <= 1'b0;
         nr_reg    <= 5'd0;
         rc_reg    <= 4'd0;
         rkey_reg  <= '0;
         final_reg <= '0;
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         dec_reg   <= dec_next;
         nr_reg    <= nr_next;
         rc_reg    <= rc_next;
         rkey_reg  <= rkey_next;
         final_reg <= final_next;
         valid_reg <= valid_next;
         err_reg   <= err_next;
      end
   end

   assign bus.rkey        = rkey_reg;
   assign bus.rkey_final  = final_reg;
   assign bus.rkey_valid  = valid_reg;
   assign bus.round_count = rc_reg;
   assign bus.round_last  = round_last;
   assign bus.done        = (state_reg == ST_DONE);
   assign bus.err         = err_reg;

endmodule

// File: tb/tb_aria_rkey_sched.sv
// Directed + random bench for the ARIA round-key sequencer with a queue
// scoreboard of expected per-round outputs.
module tb_aria_rkey_sched;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   aria_rkey_sched_if #(.KW(128)) bus ();

   aria_rkey_sched dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [127:0] key;
      logic [3:0]   rc;
      logic         last;
   } exp_t;

   exp_t         sb[$];
   logic [127:0] ek_m [17];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_k(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_c(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Reference ARIA diffusion layer, written out byte by byte.
   function automatic logic [127:0] a_model(input logic [127:0] v);
      logic [7:0]   x [16];
      logic [7:0]   y [16];
      logic [127:0] r;
      for (int i = 0; i < 16; i++) x[i] = v[127-8*i -: 8];
      y[0]  = x[3]^x[4]^x[6]^x[8]^x[9]^x[13]^x[14];
      y[1]  = x[2]^x[5]^x[7]^x[8]^x[9]^x[12]^x[15];
      y[2]  = x[1]^x[4]^x[6]^x[10]^x[11]^x[12]^x[15];
      y[3]  = x[0]^x[5]^x[7]^x[10]^x[11]^x[13]^x[14];
      y[4]  = x[0]^x[2]^x[5]^x[8]^x[11]^x[14]^x[15];
      y[5]  = x[1]^x[3]^x[4]^x[9]^x[10]^x[14]^x[15];
      y[6]  = x[0]^x[2]^x[7]^x[9]^x[10]^x[12]^x[13];
      y[7]  = x[1]^x[3]^x[6]^x[8]^x[11]^x[12]^x[13];
      y[8]  = x[0]^x[1]^x[4]^x[7]^x[10]^x[13]^x[15];
      y[9]  = x[0]^x[1]^x[5]^x[6]^x[11]^x[12]^x[14];
      y[10] = x[2]^x[3]^x[5]^x[6]^x[8]^x[13]^x[15];
      y[11] = x[2]^x[3]^x[4]^x[7]^x[9]^x[12]^x[14];
      y[12] = x[1]^x[2]^x[6]^x[7]^x[9]^x[11]^x[12];
      y[13] = x[0]^x[3]^x[6]^x[7]^x[8]^x[10]^x[13];
      y[14] = x[0]^x[3]^x[4]^x[5]^x[9]^x[11]^x[14];
      y[15] = x[1]^x[2]^x[4]^x[5]^x[8]^x[10]^x[15];
      r = '0;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = y[i];
      return r;
   endfunction

   function automatic int nr_m(input logic [1:0] kl);
      if (kl == 2'd1) return 14;
      if (kl == 2'd2) return 16;
      return 12;
   endfunction

   task automatic write_key(input int idx, input logic [127:0] key);
      bus.wr_en  = 1'b1;
      bus.wr_idx = 5'(idx);
      bus.wr_key = key;
      step();
      bus.wr_en  = 1'b0;
      ek_m[idx]  = key;
      chk_b($sformatf("wr%0d_err", idx), bus.err, 1'b0);
   endtask

   task automatic check_zero(input string tag);
      chk_k({tag, "_rkey"},  bus.rkey, '0);
      chk_k({tag, "_final"}, bus.rkey_final, '0);
      chk_b({tag, "_valid"}, bus.rkey_valid, 1'b0);
      chk_c({tag, "_rc"},    bus.round_count, 4'd0);
      chk_b({tag, "_last"},  bus.round_last, 1'b0);
      chk_b({tag, "_done"},  bus.done, 1'b0);
      chk_b({tag, "_err"},   bus.err, 1'b0);
   endtask

   // One key sequence. Optional: stall adv, poke an illegal write/start mid-run,
   // abort with reset, write a key in the start cycle, override one expectation.
   task automatic run_seq(input logic [1:0] kl, input logic d,
                          input int stall_at, input int stall_len,
                          input int poke_at, input int poke_kind, input int abort_at,
                          input int sw_idx, input logic [127:0] sw_key,
                          input int ovr_round, input logic [127:0] ovr_key);
      int           nr;
      int           r;
      int           budget;
      logic         exp_err;
      logic [127:0] fin;
      exp_t         e;
      nr = nr_m(kl);
      if (sw_idx >= 0) begin
         bus.wr_en    = 1'b1;
         bus.wr_idx   = 5'(sw_idx);
         bus.wr_key   = sw_key;
         ek_m[sw_idx] = sw_key;
      end
      for (int i = 0; i < nr; i++) begin
         if (i == 0) e.key = d ? ek_m[nr] : ek_m[0];
         else        e.key = d ? a_model(ek_m[nr-i]) : ek_m[i];
         if (i == ovr_round) e.key = ovr_key;
         e.rc   = 4'(i);
         e.last = (i == nr - 1);
         sb.push_back(e);
      end
      fin = d ? ek_m[0] : ek_m[nr];
      bus.klen  = kl;
      bus.dec   = d;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      r = 0;
      budget = 0;
      exp_err = 1'b0;
      while (sb.size() != 0 && budget < 100) begin
         budget++;
         e = sb[0];
         chk_b($sformatf("k%0d_d%0d_r%0d_valid", kl, d, r), bus.rkey_valid, 1'b1);
         chk_b($sformatf("k%0d_d%0d_r%0d_err", kl, d, r), bus.err, exp_err);
         chk_b($sformatf("k%0d_d%0d_r%0d_done", kl, d, r), bus.done, 1'b0);
         chk_k($sformatf("k%0d_d%0d_r%0d_rkey", kl, d, r), bus.rkey, e.key);
         chk_c($sformatf("k%0d_d%0d_r%0d_rc", kl, d, r), bus.round_count, e.rc);
         chk_b($sformatf("k%0d_d%0d_r%0d_last", kl, d, r), bus.round_last, e.last);
         chk_k($sformatf("k%0d_d%0d_r%0d_final", kl, d, r), bus.rkey_final, fin);
         exp_err = 1'b0;
         if (r == abort_at) begin
            rst_n = 1'b0;
            #1;
            check_zero("abort_async");
            step();
            check_zero("abort_edge");
            rst_n = 1'b1;
            sb.delete();
            for (int i = 0; i < 17; i++) ek_m[i] = '0;
            $display("[TB] seq klen=%0d dec=%0d aborted at round %0d", kl, d, r);
            return;
         end
         if (r == stall_at && stall_len > 0) begin
            bus.adv = 1'b0;
            stall_len--;
            step();
            continue;
         end
         void'(sb.pop_front());
         bus.adv = 1'b1;
         if (r == poke_at) begin
            if (poke_kind == 1) begin
               bus.wr_en  = 1'b1;
               bus.wr_idx = 5'd3;
               bus.wr_key = ~ek_m[3];
            end else begin
               bus.start = 1'b1;
               bus.klen  = 2'd0;
               bus.dec   = ~d;
            end
            exp_err = 1'b1;
         end
         step();
         bus.adv   = 1'b0;
         bus.wr_en = 1'b0;
         bus.start = 1'b0;
         r++;
      end
      n_tests++;
      assert (budget < 100) else begin
         n_fail++;
         $error("FAIL k%0d_d%0d_timeout: observed %0d rounds left expected 0", kl, d, sb.size());
      end
      sb.delete();
      chk_b($sformatf("k%0d_d%0d_done_pulse", kl, d), bus.done, 1'b1);
      chk_b($sformatf("k%0d_d%0d_done_valid", kl, d), bus.rkey_valid, 1'b0);
      chk_b($sformatf("k%0d_d%0d_done_err", kl, d), bus.err, exp_err);
      step();
      chk_b($sformatf("k%0d_d%0d_done_clear", kl, d), bus.done, 1'b0);
      $display("[TB] seq klen=%0d dec=%0d rounds=%0d", kl, d, r);
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      bus.klen   = 2'd0;
      bus.wr_en  = 1'b0;
      bus.wr_idx = 5'd0;
      bus.wr_key = '0;
      bus.start  = 1'b0;
      bus.dec    = 1'b0;
      bus.adv    = 1'b0;
      for (int i = 0; i < 17; i++) ek_m[i] = '0;
      step();
      step();
      check_zero("reset");
      rst_n = 1'b1;
      step();

      // 1: ARIA-128 encryption order, adv every cycle.
      for (int i = 0; i < 13; i++) write_key(i, {16{8'(i + 1)}});
      run_seq(2'd0, 1'b0, -1, 0, -1, 0, -1, -1, '0, -1, '0);

      // 2: ARIA-128 decryption; round 7 = A(ek[5]) checked against a literal.
      write_key(5, {8'hA5, 120'h0});
      run_seq(2'd0, 1'b1, -1, 0, -1, 0, -1, -1, '0,
              7, 128'h000000A5_A500A500_A5A50000_00A5A500);

      // 3: ARIA-256 decryption with a 5-cycle adv stall at round 4.
      for (int i = 13; i < 17; i++) write_key(i, {16{8'(i + 1)}});
      run_seq(2'd2, 1'b1, 4, 5, -1, 0, -1, -1, '0, -1, '0);

      // 4: illegal write and illegal start during RUN, then idle rejections.
      run_seq(2'd1, 1'b0, -1, 0, 2, 1, -1, -1, '0, -1, '0);
      run_seq(2'd1, 1'b0, -1, 0, 5, 2, -1, -1, '0, -1, '0);
      bus.klen  = 2'd3;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk_b("klen3_err", bus.err, 1'b1);
      chk_b("klen3_valid", bus.rkey_valid, 1'b0);
      step();
      chk_b("klen3_err_clear", bus.err, 1'b0);
      chk_b("klen3_stay_idle", bus.rkey_valid, 1'b0);
      bus.wr_en  = 1'b1;
      bus.wr_idx = 5'd17;
      bus.wr_key = '1;
      step();
      bus.wr_en = 1'b0;
      chk_b("wr_idx17_err", bus.err, 1'b1);
      step();
      chk_b("wr_idx17_err_clear", bus.err, 1'b0);
      run_seq(2'd2, 1'b0, -1, 0, -1, 0, -1, -1, '0, -1, '0);

      // 5: reset at round 6, cleared storage, reload, decrypt.
      run_seq(2'd0, 1'b0, -1, 0, -1, 0, 6, -1, '0, -1, '0);
      run_seq(2'd0, 1'b0, -1, 0, -1, 0, -1, -1, '0, -1, '0);
      for (int i = 0; i < 13; i++) write_key(i, {16{8'(i + 1)}});
      run_seq(2'd0, 1'b1, -1, 0, -1, 0, -1, -1, '0, -1, '0);

      // 6: random keys, every key length and direction; start-cycle writes forwarded.
      for (int i = 0; i < 17; i++) write_key(i, {$urandom(), $urandom(), $urandom(), $urandom()});
      for (int k = 0; k < 3; k++) begin
         for (int dd = 0; dd < 2; dd++) begin
            if (k == 1 && dd == 0)
               run_seq(2'(k), 1'(dd), -1, 0, -1, 0, -1, 0,
                       {$urandom(), $urandom(), $urandom(), $urandom()}, -1, '0);
            else if (k == 2 && dd == 1)
               run_seq(2'(k), 1'(dd), -1, 0, -1, 0, -1, 16,
                       {$urandom(), $urandom(), $urandom(), $urandom()}, -1, '0);
            else
               run_seq(2'(k), 1'(dd), -1, 0, -1, 0, -1, -1, '0, -1, '0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
